// File: rtl/vec_mem_pkg.sv
// Shared defaults and types for the vector load path.
package vec_mem_pkg;

    localparam int unsigned WIDTH        = 24;
    localparam int unsigned DEPTH        = 10000;
    localparam int unsigned VECTOR_WIDTH = 8;
    localparam int unsigned ADDR_OFFSET  = 24;

    typedef logic [VECTOR_WIDTH-1:0][WIDTH-1:0] vec_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP,
        ERR
    } rd_state_e;

endpackage

// File: rtl/vec_mem_reader.sv
// Vector load unit: gathers VECTOR_WIDTH consecutive RAM words through one
// synchronous read port; lane VECTOR_WIDTH-1 holds the lowest address.
module vec_mem_reader #(
    parameter int unsigned WIDTH        = vec_mem_pkg::WIDTH,
    parameter int unsigned DEPTH        = vec_mem_pkg::DEPTH,
    parameter int unsigned VECTOR_WIDTH = vec_mem_pkg::VECTOR_WIDTH,
    parameter int unsigned ADDR_OFFSET  = vec_mem_pkg::ADDR_OFFSET
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [WIDTH-1:0]                   req_addr,
    output logic                               mem_re,
    output logic [WIDTH-1:0]                   mem_addr,
    input  logic [WIDTH-1:0]                   mem_rdata,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [VECTOR_WIDTH-1:0][WIDTH-1:0] rsp_data,
    output logic                               rsp_err
);
    import vec_mem_pkg::*;

    localparam int unsigned      CW       = $clog2(VECTOR_WIDTH) + 1;
    localparam logic [WIDTH-1:0] OFFSET   = WIDTH'(ADDR_OFFSET);
    localparam logic [WIDTH-1:0] PHYS_MAX = WIDTH'(DEPTH - VECTOR_WIDTH);
    localparam logic [CW-1:0]    N_WORDS  = CW'(VECTOR_WIDTH);

    rd_state_e        state;
    logic [WIDTH-1:0] phys_q;
    logic [CW-1:0]    issue_cnt;
    logic [CW-1:0]    cap_cnt;
    logic             cap_pending;

    logic [WIDTH-1:0] req_phys;
    logic             req_legal;

    assign req_phys  = req_addr - OFFSET;
    assign req_legal = (req_addr >= OFFSET) && (req_phys <= PHYS_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            phys_q      <= '0;
            issue_cnt   <= '0;
            cap_cnt     <= '0;
            cap_pending <= 1'b0;
            req_ready   <= 1'b1;
            mem_re      <= 1'b0;
            mem_addr    <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
        end else begin
            // mem_re is registered, so read data lands one edge after it was seen high
            cap_pending <= mem_re;
            if (cap_pending) begin
                for (int unsigned i = 0; i < VECTOR_WIDTH; i++) begin
                    if (cap_cnt == CW'(VECTOR_WIDTH - 1 - i)) begin
                        rsp_data[i] <= mem_rdata;
                    end
                end
                cap_cnt <= cap_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        phys_q    <= req_phys;
                        rsp_data  <= '0;
                        cap_cnt   <= '0;
                        req_ready <= 1'b0;
                        if (req_legal) begin
                            state     <= ISSUE;
                            mem_re    <= 1'b1;
                            mem_addr  <= req_phys;
                            issue_cnt <= CW'(1);
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                ISSUE: begin
                    // word 0 is issued on acceptance; issue_cnt names the next word
                    if (issue_cnt == N_WORDS) begin
                        mem_re <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        mem_addr  <= phys_q + WIDTH'(issue_cnt);
                        issue_cnt <= issue_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (cap_pending) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                ERR: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mem_reader.sv
// Directed bench for vec_mem_reader with a 1-cycle synchronous RAM model.
module tb_vec_mem_reader;

    localparam int unsigned W     = vec_mem_pkg::WIDTH;
    localparam int unsigned DEPTH = vec_mem_pkg::DEPTH;
    localparam int unsigned VW    = vec_mem_pkg::VECTOR_WIDTH;
    localparam int unsigned OFFS  = vec_mem_pkg::ADDR_OFFSET;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic                    clk;
    logic                    rst_n;
    logic                    req_valid;
    logic                    req_ready;
    logic [W-1:0]            req_addr;
    logic                    mem_re;
    logic [W-1:0]            mem_addr;
    logic [W-1:0]            mem_rdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [VW-1:0][W-1:0]    rsp_data;
    logic                    rsp_err;

    vec_mem_reader #(
        .WIDTH       (W),
        .DEPTH       (DEPTH),
        .VECTOR_WIDTH(VW),
        .ADDR_OFFSET (OFFS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] ram [DEPTH];

    always @(posedge clk) begin : vec_ram_model
        if (mem_re && (mem_addr < W'(DEPTH))) mem_rdata <= ram[mem_addr[AW-1:0]];
    end

    typedef struct {
        logic [W-1:0] addr;
        logic         err;
        logic [W-1:0] phys;
    } vec_rec_t;

    int total;
    int bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] exp_lane(input logic [W-1:0] phys, input int unsigned lane);
        logic [W-1:0] idx;
        idx = phys + W'(VW - 1 - lane);
        return ram[idx[AW-1:0]];
    endfunction

    task automatic check_vec(input string tag, input logic [W-1:0] phys, input logic err);
        for (int i = 0; i < VW; i++) begin
            check($sformatf("%s_lane%0d", tag, i), 32'(rsp_data[i]),
                  err ? 32'd0 : 32'(exp_lane(phys, i)));
        end
    endtask

    task automatic run_vec(input vec_rec_t r);
        int n;
        int issued;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_addr  = r.addr;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("req_ready_busy", 32'(req_ready), 32'd0);
        n = 0;
        issued = 0;
        while (!rsp_valid && n < 20) begin
            if (mem_re) begin
                check("mem_addr_seq", 32'(mem_addr), 32'(r.phys) + 32'(issued));
                issued++;
            end
            step();
            n++;
        end
        check("rsp_latency", 32'(n), r.err ? 32'd1 : 32'd9);
        check("read_count", 32'(issued), r.err ? 32'd0 : 32'(VW));
        check("rsp_err", 32'(rsp_err), 32'(r.err));
        check_vec("rsp_data", r.phys, r.err);
        if (!r.err) check("mem_addr_hold", 32'(mem_addr), 32'(r.phys) + 32'(VW - 1));
        step();
        rsp_ready = 1'b0;
        check("rsp_valid_done", 32'(rsp_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    vec_rec_t tbl [8];

    initial begin
        int n;
        int seen;
        total = 0;
        bad   = 0;

        tbl[0] = '{addr: 24'd24,       err: 1'b0, phys: 24'd0};
        tbl[1] = '{addr: 24'd10016,    err: 1'b0, phys: 24'd9992};
        tbl[2] = '{addr: 24'd10017,    err: 1'b1, phys: 24'd0};
        tbl[3] = '{addr: 24'd23,       err: 1'b1, phys: 24'd0};
        tbl[4] = '{addr: 24'd0,        err: 1'b1, phys: 24'd0};
        tbl[5] = '{addr: 24'hFFFFFF,   err: 1'b1, phys: 24'd0};
        tbl[6] = '{addr: 24'd10015,    err: 1'b0, phys: 24'd9991};
        tbl[7] = '{addr: 24'd31,       err: 1'b0, phys: 24'd7};

        for (int k = 0; k < DEPTH; k++) ram[k] = 24'h5A0000 + W'(k);
        for (int k = 0; k < 16; k++) ram[k] = 24'h000100 + W'(k);

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        repeat (3) step();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_vec("rst_data", '0, 1'b1);
        rst_n = 1'b1;
        step();

        for (int t = 0; t < 8; t++) run_vec(tbl[t]);

        // back-pressure: response held 5 cycles while a second request waits
        req_addr  = 24'd24;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("bp_latency", 32'(n), 32'd9);
        req_addr  = 24'd31;
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_mem_re", 32'(mem_re), 32'd0);
            check("bp_lane7", 32'(rsp_data[7]), 32'h100);
            check("bp_lane0", 32'(rsp_data[0]), 32'h107);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check("bp_second_accept", 32'(req_ready), 32'd0);
        check("bp_second_re", 32'(mem_re), 32'd1);
        check("bp_second_addr", 32'(mem_addr), 32'd7);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("bp_second_latency", 32'(n), 32'd9);
        check_vec("bp_second_data", 24'd7, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_second_done", 32'(rsp_valid), 32'd0);

        // reset during the 4th issue cycle
        req_addr  = 24'd24;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        check("mid_issue_active", 32'(mem_re), 32'd1);
        rst_n = 1'b0;
        step();
        check("mid_rst_mem_re", 32'(mem_re), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check_vec("mid_rst_data", '0, 1'b1);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (rsp_valid || mem_re) seen++;
        end
        check("mid_rst_quiet", 32'(seen), 32'd0);
        run_vec('{addr: 24'd40, err: 1'b0, phys: 24'd16});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_mem_reader.md
# vec_mem_reader

Vector load unit for the vector datapath: accepts one base address, gathers `VECTOR_WIDTH` consecutive words from the shared data RAM through a single synchronous read port, and returns them as one vector. It sits between the vector register file's load path and the data RAM. It is the read-side counterpart of the vector store path, and its lane/address mapping exactly mirrors that store path, so a store followed by a load at the same address round-trips a vector unchanged.

## Interface

Parameters:
- `WIDTH`, 24, word width and address width.
- `DEPTH`, 10000, RAM words.
- `VECTOR_WIDTH`, 8, lanes per vector.
- `ADDR_OFFSET`, 24, processor-address offset subtracted to form the RAM index.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  1  load request present.
- `req_ready`  out  1  unit can accept a request.
- `req_addr`  in  WIDTH  processor base address.
- `mem_re`  out  1  RAM read enable, one word per cycle.
- `mem_addr`  out  WIDTH  RAM word index.
- `mem_rdata`  in  WIDTH  RAM read data, valid the cycle after `mem_re`.
- `rsp_valid`  out  1  vector result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_data`  out  [VECTOR_WIDTH-1:0][WIDTH-1:0]  gathered vector.
- `rsp_err`  out  1  request was out of range; `rsp_data` is all zero.

## Operation

- **Physical base:** `phys = req_addr - ADDR_OFFSET`, computed modulo 2^WIDTH.
- **Range check:** the request is legal only if `req_addr >= ADDR_OFFSET` and `phys <= DEPTH - VECTOR_WIDTH`. All lanes must be in range; partial loads are never performed.
- **Lane mapping:** lane `VECTOR_WIDTH-1-k` receives `RAM[phys+k]` for k = 0..VECTOR_WIDTH-1. Lane 7 holds the lowest address and lane 0 the highest.
- **FSM states:** IDLE, ISSUE, DRAIN, RESP, ERR.
  - IDLE: `req_ready=1`. On `req_valid`, latch `phys`. Go to ISSUE if legal, otherwise go to ERR.
  - ISSUE: `mem_re=1`, `mem_addr = phys + issue_cnt`. `issue_cnt` counts 0..VECTOR_WIDTH-1. After the last issue, go to DRAIN.
  - Capture runs in parallel with ISSUE and DRAIN. Each cycle after a read, `mem_rdata` is written into lane `VECTOR_WIDTH-1-cap_cnt` and `cap_cnt` increments.
  - DRAIN: capture the final word, then go to RESP.
  - RESP: `rsp_valid=1`, `rsp_err=0`. Hold `rsp_data` stable until `rsp_ready`, then go to IDLE.
  - ERR: `rsp_valid=1`, `rsp_err=1`, `rsp_data=0`. No `mem_re` is issued. Leave on `rsp_ready`, then go to IDLE.
- **Back-pressure:** `req_ready=0` in every state except IDLE. A new request can be accepted no earlier than the cycle after the response handshake.
- **Outputs outside ISSUE:** `mem_re=0`. `mem_addr` holds its last value.
- **rsp_data clearing:** `rsp_data` is cleared to zero when a new request is accepted.

## Timing

- **Reset values:** when `rst_n=0` at a posedge, state becomes IDLE and `req_ready=1`. `mem_re`, `mem_addr`, `rsp_valid`, `rsp_data`, `rsp_err` and both counters are all 0.
- **Reset mid-operation:** abandons the load immediately. No response is produced, and the next cycle shows reset values.
- **Acceptance:** the request is accepted at edge E0.
  - `mem_re` is high for exactly VECTOR_WIDTH cycles, between E0 and E8.
  - Captures occur at E2..E9.
  - `rsp_valid` is high starting after E9, i.e. 9 edges after acceptance.
- **Error path:** `rsp_valid` is high starting after E1.
- **Response hold:** `rsp_valid` stays high until the edge at which `rsp_ready=1`. `rsp_ready` arriving in the same cycle `rsp_valid` rises is legal and completes the transfer at that edge.
- **Ignored inputs:** `rsp_ready` is ignored when `rsp_valid=0`. `req_valid` is ignored when `req_ready=0`.
- **Counter widths:** both counters are `$clog2(VECTOR_WIDTH)+1` bits wide. `phys + issue_cnt` never wraps, because legality is checked first.

## Structure

- **Package `vec_mem_pkg`:** holds the `WIDTH`, `VECTOR_WIDTH`, `DEPTH` and `ADDR_OFFSET` defaults, the `vec_t` typedef (`logic [VECTOR_WIDTH-1:0][WIDTH-1:0]`), and the `rd_state_e` enum.
- **RTL:** a single module with no sub-modules.
- **Bench:** a synchronous-read RAM model, `vec_ram_model`, with 1-cycle latency and preloadable contents.

## Test plan

- **Reset:** hold `rst_n=0` for 3 cycles → `req_ready=1`; `rsp_valid`, `mem_re` and `rsp_data` all 0.
- **Legal load:** preload RAM[k]=k+0x100 for k=0..15; request `req_addr=24` with `rsp_ready=1` →
  - `mem_addr` sequence is 0..7 over 8 cycles;
  - `rsp_valid` rises 9 edges after acceptance;
  - `rsp_data[7]=0x100`, `rsp_data[0]=0x107`, `rsp_err=0`.
- **Upper boundary:** `req_addr=10016` (phys 9992) → legal, reads 9992..9999. `req_addr=10017` → `rsp_err=1`, `rsp_data=0`, no `mem_re`, response after 1 edge.
- **Lower boundary:** `req_addr=23` and `req_addr=0` → `rsp_err=1`. Also verify `req_addr=0xFFFFFF` returns `rsp_err=1`.
- **Back-pressure:** hold `rsp_ready=0` for 5 cycles after `rsp_valid` → data stable, `req_ready=0`, extra `req_valid` ignored. Release → IDLE next cycle and the second request is accepted.
- **Reset mid-operation:** assert `rst_n=0` on the 4th ISSUE cycle → next cycle `mem_re=0`, no `rsp_valid`. A following legal load returns correct data.
